obi_scheduler: RTL
==================

OBI_SCHEDULER -- requirements
Module: obi_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 2: number of requesters (>=2, else elaboration $fatal).
REQ-002 SHALL have parameter NumMaxTrans, default 4: total outstanding transactions (response FIFO depth, >=1).
REQ-003 SHALL have parameter MaxTransPerPort, default 2: per-requester outstanding limit (1..NumMaxTrans).
REQ-004 SHALL have parameter StarvLimit, default 15: wait cycles before a requester is promoted to starving class (>=1).
REQ-005 SHALL derive IdxW = max(1, $clog2(NumReq)) and CntW = $clog2(NumMaxTrans+1).
REQ-006 SHALL have port clk_i, input, 1: single clock, all state rising-edge.
REQ-007 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-008 SHALL have port req_i, input, NumReq: per-requester OBI req.
REQ-009 SHALL have port prio_i, input, NumReq: per-requester high-priority flag.
REQ-010 SHALL have port gnt_o, output, NumReq: per-requester OBI gnt.
REQ-011 SHALL have ports mgr_req_o (output, 1), mgr_gnt_i (input, 1), sel_idx_o (output, IdxW): manager A-channel handshake and index of the requester whose A-channel is muxed out.
REQ-012 SHALL have port mgr_rvalid_i, input, 1: manager response valid.
REQ-013 SHALL have ports rsp_valid_o (output, NumReq, one-hot) and rsp_idx_o (output, IdxW): response routing.
REQ-014 SHALL have ports outstanding_o (output, CntW) and protocol_err_o (output, 1): total in flight and one-cycle error pulse.

Function
REQ-015 SHALL define eligible[i] = req_i[i] && cnt[i] < MaxTransPerPort.
REQ-016 SHALL select among eligible requesters in class order starving > prio_i > normal, round-robin within a class, starting from rr_ptr.
REQ-017 SHALL drive mgr_req_o = (lock || any eligible) && !fifo_full && !rst_i.
REQ-018 SHALL hold sel_idx_o locked on the previous selection while mgr_req_o was high and mgr_gnt_i low, ignoring new or higher-class requests.
REQ-019 SHALL assert gnt_o[sel_idx_o] = mgr_req_o && mgr_gnt_i combinationally; all other gnt_o bits 0.
REQ-020 SHALL on accept (mgr_req_o && mgr_gnt_i): push sel_idx_o to FIFO, increment cnt[sel], set rr_ptr = sel+1 mod NumReq, clear lock and wait[sel].
REQ-021 SHALL increment wait[i] each cycle req_i[i] is high and not granted, saturating at StarvLimit, and clear it when req_i[i] is low.
REQ-022 SHALL treat wait[i] == StarvLimit as starving.
REQ-023 SHALL on mgr_rvalid_i with FIFO non-empty: rsp_idx_o = FIFO head, rsp_valid_o[head] = 1 in the same cycle, pop, decrement cnt[head].
REQ-024 SHALL on mgr_rvalid_i with FIFO empty: rsp_valid_o = 0, no state change, protocol_err_o = 1 for that cycle.
REQ-025 SHALL leave cnt[i] unchanged on simultaneous accept and response for the same i; outstanding_o = FIFO usage.
REQ-026 SHALL not fall through: a pushed index is visible at the head no earlier than the next cycle.
REQ-027 SHALL drop mgr_req_o and all gnt_o when FIFO is full, keeping lock; a pop in the same cycle frees space the next cycle.
REQ-028 SHALL drive rsp_idx_o = 0 when the FIFO is empty.

Reset
REQ-029 SHALL on rst_i clear FIFO, cnt[], wait[], rr_ptr = 0 and lock, even with transactions in flight; responses arriving afterwards raise protocol_err_o.
REQ-030 SHALL force mgr_req_o, gnt_o, rsp_valid_o, protocol_err_o, sel_idx_o and outstanding_o to 0 while rst_i is high.

Structure
REQ-031 SHALL place the selection-class enum (CLASS_STARVING, CLASS_PRIO, CLASS_NORMAL) in obi_pkg.
REQ-032 SHALL instantiate exactly one sub-module, fifo_v3 (FALL_THROUGH 0, DATA_WIDTH IdxW, DEPTH NumMaxTrans), for the response-order FIFO.
REQ-033 SHALL keep the round-robin class selection as inline logic, not a separate module.

Verification
REQ-034 SHALL cover round-robin: NumReq=2, req_i=11 every cycle, mgr_gnt_i=1 -> grants alternate 0,1,0,1; each mgr_rvalid_i routes rsp_valid_o 01,10 in grant order.
REQ-035 SHALL cover lock: req_i=01, mgr_gnt_i=0 for 3 cycles, then req_i[1] with prio_i=10 -> sel_idx_o stays 0 until granted, then 1.
REQ-036 SHALL cover per-port limit: MaxTransPerPort=2, no responses -> port 0 granted twice, third request stalls; one mgr_rvalid_i -> regranted next cycle.
REQ-037 SHALL cover starvation: StarvLimit=3, prio_i=10, both requesting continuously -> port 0 granted after at most 4 cycles of waiting.
REQ-038 SHALL cover FIFO full: NumMaxTrans=4, 4 accepts, no responses -> mgr_req_o=0, outstanding_o=4; pop plus request in the same cycle -> accept next cycle.
REQ-039 SHALL cover errors and reset: mgr_rvalid_i with FIFO empty -> protocol_err_o pulses 1 cycle; rst_i with 3 outstanding -> outstanding_o=0 next cycle.

Source files
------------

// File: rtl/obi_pkg.sv
// Shared types for the OBI request scheduler.
package obi_pkg;

    // Lower value wins: starving requesters beat prioritised ones, which beat normal ones.
    typedef enum logic [1:0] {
        CLASS_STARVING = 2'd0,
        CLASS_PRIO     = 2'd1,
        CLASS_NORMAL   = 2'd2
    } sel_class_e;

endpackage

// File: rtl/fifo_v3.sv
// Simple circular FIFO with optional fall-through and a synchronous active-high reset.
module fifo_v3 #(
    parameter bit FALL_THROUGH = 1'b0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    localparam int AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int UsageW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [UsageW-1:0]     usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0]      rd_ptr, wr_ptr;
    logic [UsageW-1:0]     usage;
    logic                  do_push, do_pop;

    function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
        return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (usage == UsageW'(DEPTH));
    assign empty_o = (usage == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = usage;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        data_o = mem[rd_ptr];
        if (FALL_THROUGH && usage == '0) data_o = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            usage  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      usage <= usage + 1'b1;
            else if (do_pop && !do_push) usage <= usage - 1'b1;
        end
    end

endmodule

// File: rtl/obi_scheduler.sv
// Multi-requester OBI A-channel scheduler: class-based round-robin with starvation
// promotion, per-port and total outstanding limits, and in-order response routing.
module obi_scheduler
    import obi_pkg::*;
#(
    parameter int  NumReq          = 2,
    parameter int  NumMaxTrans     = 4,
    parameter int  MaxTransPerPort = 2,
    parameter int  StarvLimit      = 15,
    localparam int IdxW            = (NumReq > 2) ? $clog2(NumReq) : 1,
    localparam int CntW            = $clog2(NumMaxTrans + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] prio_i,
    output logic [NumReq-1:0] gnt_o,
    output logic              mgr_req_o,
    input  logic              mgr_gnt_i,
    output logic [IdxW-1:0]   sel_idx_o,
    input  logic              mgr_rvalid_i,
    output logic [NumReq-1:0] rsp_valid_o,
    output logic [IdxW-1:0]   rsp_idx_o,
    output logic [CntW-1:0]   outstanding_o,
    output logic              protocol_err_o
);

    localparam int WaitW = $clog2(StarvLimit + 1);

    if (NumReq < 2) begin : g_chk_numreq
        $fatal(1, "obi_scheduler: NumReq must be >= 2");
    end
    if (NumMaxTrans < 1) begin : g_chk_maxtrans
        $fatal(1, "obi_scheduler: NumMaxTrans must be >= 1");
    end
    if (MaxTransPerPort < 1 || MaxTransPerPort > NumMaxTrans) begin : g_chk_perport
        $fatal(1, "obi_scheduler: MaxTransPerPort must be in 1..NumMaxTrans");
    end
    if (StarvLimit < 1) begin : g_chk_starv
        $fatal(1, "obi_scheduler: StarvLimit must be >= 1");
    end

    logic [CntW-1:0]   cnt      [NumReq];
    logic [WaitW-1:0]  wait_cnt [NumReq];
    sel_class_e        cls      [NumReq];
    logic [NumReq-1:0] eligible, acc_hit, rsp_hit;
    logic [IdxW-1:0]   rr_ptr, lock_idx, arb_idx, sel;
    logic              lock, arb_found, accept, pop;
    sel_class_e        arb_cls;
    int                j;

    logic              fifo_full, fifo_empty;
    logic [IdxW-1:0]   fifo_head;
    logic [CntW-1:0]   fifo_usage;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            eligible[i] = req_i[i] && (cnt[i] < CntW'(MaxTransPerPort));
            if (wait_cnt[i] == WaitW'(StarvLimit)) cls[i] = CLASS_STARVING;
            else if (prio_i[i])                    cls[i] = CLASS_PRIO;
            else                                   cls[i] = CLASS_NORMAL;
        end
    end

    // Scan from rr_ptr; only a strictly better class displaces an earlier hit,
    // which gives round-robin order inside each class.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cls   = CLASS_NORMAL;
        j         = 0;
        for (int k = 0; k < NumReq; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NumReq) j = j - NumReq;
            if (eligible[j] && (!arb_found || cls[j] < arb_cls)) begin
                arb_found = 1'b1;
                arb_idx   = IdxW'(j);
                arb_cls   = cls[j];
            end
        end
    end

    assign sel            = lock ? lock_idx : arb_idx;
    assign mgr_req_o      = (lock || arb_found) && !fifo_full && !rst_i;
    assign accept         = mgr_req_o && mgr_gnt_i;
    assign pop            = mgr_rvalid_i && !fifo_empty && !rst_i;
    assign sel_idx_o      = rst_i ? '0 : sel;
    assign rsp_idx_o      = (fifo_empty || rst_i) ? '0 : fifo_head;
    assign outstanding_o  = rst_i ? '0 : fifo_usage;
    assign protocol_err_o = mgr_rvalid_i && fifo_empty && !rst_i;

    always_comb begin
        gnt_o       = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            acc_hit[i] = accept && (sel == IdxW'(i));
            rsp_hit[i] = pop && (fifo_head == IdxW'(i));
        end
        if (accept) gnt_o[sel] = 1'b1;
        if (pop)    rsp_valid_o[fifo_head] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            for (int i = 0; i < NumReq; i++) begin
                cnt[i]      <= '0;
                wait_cnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
                lock   <= 1'b0;
            end else if (mgr_req_o) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end
            for (int i = 0; i < NumReq; i++) begin
                if (acc_hit[i] && !rsp_hit[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (rsp_hit[i] && !acc_hit[i]) cnt[i] <= cnt[i] - 1'b1;
                if (!req_i[i] || acc_hit[i])               wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WaitW'(StarvLimit)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
        end
    end

    // Response order FIFO: holds the requester index of every accepted transaction.
    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (NumMaxTrans)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (sel),
        .push_i  (accept),
        .data_o  (fifo_head),
        .pop_i   (pop)
    );

endmodule
